irq_pending_ctrl: RTL
=====================

# irq_pending_ctrl

- Request-capture and service-handshake stage directly upstream of the 4:2 priority encoder.
- Captures four raw interrupt lines into a pending register, applies a software mask, and drives the masked pending vector to the encoder.
- Takes the encoder's 2-bit index back, freezes it, and runs a request/acknowledge/end-of-service handshake with the consumer.

## Interface
Parameters:
- EDGE, 1, trigger mode: 1 = set pending on rising edge of the request, 0 = set pending while the request is high (level).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- irq_in  in  4  raw interrupt request lines, bit 3 highest priority
- mask_wr  in  1  mask write strobe
- mask_din  in  4  new mask value; 1 = line enabled
- mask  out  4  current mask register
- pend  out  4  pending & mask, to encoder input
- enc_idx  in  2  encoder output index for the current pend
- irq_req  out  1  interrupt request to consumer
- irq_id  out  2  frozen id of the request being presented or serviced
- irq_ack  in  1  consumer accepts the request
- eoi  in  1  consumer end of service
- busy  out  1  service in progress

## Operation
- Pending register is 4 bits, stored unmasked. `pend` is combinational: pending & mask.
- Sampled request per line:
  - EDGE=1: set pending when sampled request is 1 and its history flop is 0.
  - EDGE=0: set pending whenever the sampled request is 1.
- Mask: `mask_wr` loads `mask_din` at the next edge. Pending bits are retained while masked and appear on `pend` once unmasked.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if pend != 0, load irq_id <= enc_idx and go to REQ.
  - REQ: irq_req = 1. irq_id stays frozen, even if a higher-priority line arrives or the line is masked. On irq_ack, clear pending[irq_id] and go to SERVICE.
  - SERVICE: busy = 1. On eoi, go to IDLE.
- Ignored inputs: irq_ack outside REQ; eoi outside SERVICE. If irq_ack and eoi arrive together in REQ, only ack is processed.
- A set and a clear on the same pending bit in the same cycle: set wins, so a new edge is never lost.
  - In level mode (EDGE=0), a line still high after ack re-pends on the next cycle.
- Capture continues in all states. Edges arriving during REQ or SERVICE are queued in pending.

## Timing
- Reset values: pending 0, history/sync flops 0, mask 4'b0000, FSM IDLE, irq_req 0, irq_id 2'd0, busy 0. pend is therefore 0.
- A request already high when reset releases counts as a rising edge.
- Reset asserted mid-operation returns everything to reset values immediately. Pending requests are lost.
- Latency from the clk edge that first samples irq_in high:
  - pending visible after 1 edge without sync, 3 edges with IRQ_SYNC_EN;
  - irq_req high 1 cycle after pend != 0 is seen in IDLE.
- irq_ack sampled high in REQ: irq_req and the pending bit drop, and busy rises, at the same edge.
- Minimum turnaround from eoi to next irq_req is 2 cycles (eoi edge to IDLE, then IDLE to REQ).

## Configuration
- IRQ_SYNC_EN defined: each irq_in bit passes through a two-flop synchronizer before edge/level detection. Adds 2 cycles of latency; irq_in may be asynchronous to clk.
- IRQ_SYNC_EN undefined: irq_in is used directly as the sampled request and must be synchronous to clk. The history flop is still present for edge mode.

## Test plan
- Reset, mask_din=4'hF written, irq_in[2] pulsed for 1 cycle (EDGE=1, no sync) -> pend=4'b0100 one edge later; irq_req=1 and irq_id=2 one cycle after; irq_ack -> pend=0, busy=1; eoi -> busy=0, IDLE.
- irq_in[0] rises while state is REQ with irq_id=1, then irq_in[3] rises -> irq_id stays 1 until ack; after eoi, next request presents irq_id=3, then irq_id=0.
- Mask 4'b0000, pulse irq_in[1] -> pend=0 and irq_req stays 0; write mask 4'b0010 -> pend=4'b0010, irq_req=1 with irq_id=1.
- irq_in[2] rising edge in the same cycle as irq_ack for irq_id=2 -> pending[2] remains 1 and re-requests after eoi.
- With IRQ_SYNC_EN: irq_in[3] rises -> pend[3] rises 3 edges after first sample, irq_req 1 cycle later. rst_n pulled low in SERVICE -> busy, irq_req, pend and mask are all 0 asynchronously.
- EDGE=0, irq_in[1] held high -> after ack and eoi the line re-requests with irq_id=1 every service cycle.

Source files
------------

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: interrupt capture and service handshake stage.
//
// Captures four raw interrupt lines into an unmasked pending register.
// Drives pending & mask to an external 4:2 priority encoder. Freezes the
// returned index and runs a req/ack/eoi handshake with the consumer.
//
// Parameters:
//   EDGE      1 = pend on rising edge of the sampled request, 0 = level
// Macros:
//   IRQ_SYNC_EN  when defined, irq_in passes through a two-flop synchronizer
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   irq_in    raw interrupt lines, bit 3 highest priority
//   mask_wr   mask write strobe
//   mask_din  new mask value (1 = line enabled)
//   mask      current mask register
//   pend      pending & mask, to encoder input
//   enc_idx   encoder index for the current pend
//   irq_req   request to consumer
//   irq_id    frozen id of the request being presented or serviced
//   irq_ack   consumer accepts the request
//   eoi       consumer end of service
//   busy      service in progress
module irq_pending_ctrl #(
  parameter bit EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] irq_in,
  input  logic       mask_wr,
  input  logic [3:0] mask_din,
  output logic [3:0] mask,
  output logic [3:0] pend,
  input  logic [1:0] enc_idx,
  output logic       irq_req,
  output logic [1:0] irq_id,
  input  logic       irq_ack,
  input  logic       eoi,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StReq, StService} state_e;

  state_e     state_q;
  logic [3:0] req_s;
  logic [3:0] hist_q;
  logic [3:0] pending_q, pending_d;
  logic [3:0] mask_q;
  logic [3:0] set_vec, clr_vec;
  logic       irq_req_q, busy_q;
  logic [1:0] irq_id_q;

`ifdef IRQ_SYNC_EN
  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 4'b0000;
      sync2_q <= 4'b0000;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign req_s = sync2_q;
`else
  assign req_s = irq_in;
`endif

  // Set beats clear on the same bit so an edge coinciding with ack is kept.
  always_comb begin
    set_vec = EDGE ? (req_s & ~hist_q) : req_s;
    clr_vec = 4'b0000;
    if (state_q == StReq && irq_ack) begin
      clr_vec[irq_id_q] = 1'b1;
    end
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q    <= 4'b0000;
      pending_q <= 4'b0000;
      mask_q    <= 4'b0000;
    end else begin
      hist_q    <= req_s;
      pending_q <= pending_d;
      if (mask_wr) begin
        mask_q <= mask_din;
      end
    end
  end

  assign pend = pending_q & mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      irq_req_q <= 1'b0;
      irq_id_q  <= 2'd0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pend != 4'b0000) begin
            irq_id_q  <= enc_idx;
            irq_req_q <= 1'b1;
            state_q   <= StReq;
          end
        end
        StReq: begin
          // eoi in this state is ignored, even alongside ack.
          if (irq_ack) begin
            irq_req_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= StService;
          end
        end
        StService: begin
          if (eoi) begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          state_q   <= StIdle;
          irq_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign mask    = mask_q;
  assign irq_req = irq_req_q;
  assign irq_id  = irq_id_q;
  assign busy    = busy_q;

endmodule
